// File: rtl/ula_arbiter_if.sv
// Bundles the two requester channels, the ALU operand/result path and the shared
// response channel of ula_arbiter. The arbiter uses the slave modport.
interface ula_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 3
);
  logic              rq0_valid;
  logic              rq0_ready;
  logic [DATA_W-1:0] rq0_a;
  logic [DATA_W-1:0] rq0_b;
  logic [OP_W-1:0]   rq0_op;

  logic              rq1_valid;
  logic              rq1_ready;
  logic [DATA_W-1:0] rq1_a;
  logic [DATA_W-1:0] rq1_b;
  logic [OP_W-1:0]   rq1_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_x;

  logic              rs_valid;
  logic              rs_ready;
  logic              rs_id;
  logic [DATA_W-1:0] rs_data;

  modport slave (
    input  rq0_valid, rq0_a, rq0_b, rq0_op,
    output rq0_ready,
    input  rq1_valid, rq1_a, rq1_b, rq1_op,
    output rq1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_x,
    output rs_valid, rs_id, rs_data,
    input  rs_ready
  );

  modport master (
    output rq0_valid, rq0_a, rq0_b, rq0_op,
    input  rq0_ready,
    output rq1_valid, rq1_a, rq1_b, rq1_op,
    input  rq1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_x,
    input  rs_valid, rs_id, rs_data,
    output rs_ready
  );
endinterface

// File: rtl/ula_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU; one operation in flight.
// Optional grant counters are built when ULA_ARB_STATS_EN is defined.
module ula_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OP_W     = 3,
  parameter int unsigned FIX_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  ula_arbiter_if.slave    bus
`ifdef ULA_ARB_STATS_EN
  ,
  input  logic            stats_clr,
  output logic [15:0]     gnt0_cnt,
  output logic [15:0]     gnt1_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic              rs_valid_q, rs_valid_d;
  logic              rs_id_q, rs_id_d;
  logic              id_q, id_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt0, gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rs_data_q    <= '0;
      rs_valid_q   <= 1'b0;
      rs_id_q      <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rs_data_q    <= rs_data_d;
      rs_valid_q   <= rs_valid_d;
      rs_id_q      <= rs_id_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rs_data_d    = rs_data_q;
    rs_valid_d   = rs_valid_q;
    rs_id_d      = rs_id_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (bus.rq1_ready) begin
          state_d      = StExec;
          alu_a_d      = bus.rq1_a;
          alu_b_d      = bus.rq1_b;
          alu_op_d     = bus.rq1_op;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
        end else if (bus.rq0_ready) begin
          state_d      = StExec;
          alu_a_d      = bus.rq0_a;
          alu_b_d      = bus.rq0_b;
          alu_op_d     = bus.rq0_op;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
        end
      end
      StExec: begin
        state_d    = StResp;
        rs_data_d  = bus.alu_x;
        rs_id_d    = id_q;
        rs_valid_d = 1'b1;
      end
      StResp: begin
        if (bus.rs_ready) begin
          state_d    = StIdle;
          rs_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready doubles as the handshake: grants already include the requester's valid.
  always_comb begin
    gnt0 = bus.rq0_valid & (~bus.rq1_valid | (FIX_PRIO != 0) | last_grant_q);
    gnt1 = bus.rq1_valid & ~gnt0;
    bus.rq0_ready = (state_q == StIdle) & gnt0;
    bus.rq1_ready = (state_q == StIdle) & gnt1;
    bus.alu_a     = alu_a_q;
    bus.alu_b     = alu_b_q;
    bus.alu_op    = alu_op_q;
    bus.rs_valid  = rs_valid_q;
    bus.rs_id     = rs_id_q;
    bus.rs_data   = rs_data_q;
  end

`ifdef ULA_ARB_STATS_EN
  logic [15:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [15:0] gnt1_cnt_q, gnt1_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      gnt0_cnt_q <= gnt0_cnt_d;
      gnt1_cnt_q <= gnt1_cnt_d;
    end
  end

  // Clear has priority over a same-cycle grant; counts saturate instead of wrapping.
  always_comb begin
    gnt0_cnt_d = gnt0_cnt_q;
    gnt1_cnt_d = gnt1_cnt_q;
    if (stats_clr) begin
      gnt0_cnt_d = '0;
      gnt1_cnt_d = '0;
    end else begin
      if (bus.rq0_ready && gnt0_cnt_q != 16'hFFFF) gnt0_cnt_d = gnt0_cnt_q + 16'd1;
      if (bus.rq1_ready && gnt1_cnt_q != 16'hFFFF) gnt1_cnt_d = gnt1_cnt_q + 16'd1;
    end
  end

  assign gnt0_cnt = gnt0_cnt_q;
  assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own ALU model. Grant counters are exercised when ULA_ARB_STATS_EN is defined.
module tb_ula_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ula_arbiter_if #(.DATA_W(8), .OP_W(3)) rr_if ();
  ula_arbiter_if #(.DATA_W(8), .OP_W(3)) fp_if ();

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return a + b;
      3'd5:    return a - b;
      3'd6:    return a + 8'd1;
      default: return b + 8'd1;
    endcase
  endfunction

  assign rr_if.alu_x = alu_f(rr_if.alu_a, rr_if.alu_b, rr_if.alu_op);
  assign fp_if.alu_x = alu_f(fp_if.alu_a, fp_if.alu_b, fp_if.alu_op);

  assign fp_if.rq0_valid = rr_if.rq0_valid;
  assign fp_if.rq0_a     = rr_if.rq0_a;
  assign fp_if.rq0_b     = rr_if.rq0_b;
  assign fp_if.rq0_op    = rr_if.rq0_op;
  assign fp_if.rq1_valid = rr_if.rq1_valid;
  assign fp_if.rq1_a     = rr_if.rq1_a;
  assign fp_if.rq1_b     = rr_if.rq1_b;
  assign fp_if.rq1_op    = rr_if.rq1_op;
  assign fp_if.rs_ready  = rr_if.rs_ready;

`ifdef ULA_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] gnt0_cnt, gnt1_cnt, fp_gnt0_cnt, fp_gnt1_cnt;
`endif

  ula_arbiter #(.DATA_W(8), .OP_W(3), .FIX_PRIO(0)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (rr_if)
`ifdef ULA_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .gnt0_cnt  (gnt0_cnt),
    .gnt1_cnt  (gnt1_cnt)
`endif
  );

  ula_arbiter #(.DATA_W(8), .OP_W(3), .FIX_PRIO(1)) u_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (fp_if)
`ifdef ULA_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .gnt0_cnt  (fp_gnt0_cnt),
    .gnt1_cnt  (fp_gnt1_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rr_if.rq0_valid = 1'b0;
    rr_if.rq0_a     = '0;
    rr_if.rq0_b     = '0;
    rr_if.rq0_op    = '0;
    rr_if.rq1_valid = 1'b0;
    rr_if.rq1_a     = '0;
    rr_if.rq1_b     = '0;
    rr_if.rq1_op    = '0;
    rr_if.rs_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ULA_ARB_STATS_EN
  task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op);
    int k;
    @(negedge clk);
    rr_if.rs_ready = 1'b1;
    if (id) begin
      rr_if.rq1_valid = 1'b1; rr_if.rq1_a = a; rr_if.rq1_b = b; rr_if.rq1_op = op;
    end else begin
      rr_if.rq0_valid = 1'b1; rr_if.rq0_a = a; rr_if.rq0_b = b; rr_if.rq0_op = op;
    end
    #1;
    k = 0;
    while (!(id ? rr_if.rq1_ready : rr_if.rq0_ready) && k < 10) begin
      @(negedge clk); #1; k++;
    end
    check_eq("op_accept_in_time", k < 10, 1);
    @(negedge clk);
    rr_if.rq0_valid = 1'b0;
    rr_if.rq1_valid = 1'b0;
    #1;
    k = 0;
    while (!rr_if.rs_valid && k < 10) begin
      @(negedge clk); #1; k++;
    end
    check_eq("op_resp_id", rr_if.rs_id, id);
    check_eq("op_resp_data", rr_if.rs_data, alu_f(a, b, op));
    @(negedge clk);
  endtask
`endif

  initial begin
    int nr, np;
    clear_inputs();
`ifdef ULA_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_eq("rst_rs_valid", rr_if.rs_valid, 0);
    check_eq("rst_rs_id", rr_if.rs_id, 0);
    check_eq("rst_rs_data", rr_if.rs_data, 0);
    check_eq("rst_alu_a", rr_if.alu_a, 0);
    check_eq("rst_alu_b", rr_if.alu_b, 0);
    check_eq("rst_alu_op", rr_if.alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op: F0 + 20 wraps to 10
    @(negedge clk);
    rr_if.rq0_valid = 1'b1; rr_if.rq0_a = 8'hF0; rr_if.rq0_b = 8'h20; rr_if.rq0_op = 3'b100;
    rr_if.rs_ready = 1'b1;
    #1;
    check_eq("single_rq0_ready", rr_if.rq0_ready, 1);
    check_eq("single_rq1_ready", rr_if.rq1_ready, 0);
    @(negedge clk);
    rr_if.rq0_valid = 1'b0;
    #1;
    check_eq("single_alu_op", rr_if.alu_op, 3'b100);
    check_eq("single_alu_a", rr_if.alu_a, 8'hF0);
    check_eq("single_alu_b", rr_if.alu_b, 8'h20);
    check_eq("single_exec_rs_valid", rr_if.rs_valid, 0);
    @(negedge clk); #1;
    check_eq("single_rs_valid", rr_if.rs_valid, 1);
    check_eq("single_rs_data", rr_if.rs_data, 8'h10);
    check_eq("single_rs_id", rr_if.rs_id, 0);
    @(negedge clk); #1;
    check_eq("single_rs_drop", rr_if.rs_valid, 0);

    // Both requesters valid continuously: RR alternates, FP always serves rq0
    apply_reset();
    @(negedge clk);
    rr_if.rs_ready = 1'b1;
    rr_if.rq0_valid = 1'b1; rr_if.rq0_a = 8'h0F; rr_if.rq0_b = 8'h00; rr_if.rq0_op = 3'b011;
    rr_if.rq1_valid = 1'b1; rr_if.rq1_a = 8'h05; rr_if.rq1_b = 8'h07; rr_if.rq1_op = 3'b101;
    nr = 0;
    np = 0;
    for (int c = 0; c < 40 && (nr < 4 || np < 4); c++) begin
      @(negedge clk); #1;
      if (rr_if.rs_valid && nr < 4) begin
        check_eq("rr_rs_id", rr_if.rs_id, nr % 2);
        check_eq("rr_rs_data", rr_if.rs_data, (nr % 2) ? 8'hFE : 8'hF0);
        nr++;
      end
      if (fp_if.rs_valid && np < 4) begin
        check_eq("fp_rs_id", fp_if.rs_id, 0);
        check_eq("fp_rs_data", fp_if.rs_data, 8'hF0);
        np++;
      end
      check_eq("fp_rq1_ready", fp_if.rq1_ready, 0);
    end
    check_eq("rr_resp_count", nr, 4);
    check_eq("fp_resp_count", np, 4);

    // Backpressure: FF + 1 wraps to 00, held while rs_ready is low
    apply_reset();
    @(negedge clk);
    rr_if.rq1_valid = 1'b1; rr_if.rq1_a = 8'hFF; rr_if.rq1_b = 8'h00; rr_if.rq1_op = 3'b110;
    #1;
    check_eq("bp_rq1_ready", rr_if.rq1_ready, 1);
    check_eq("bp_rq0_ready", rr_if.rq0_ready, 0);
    @(negedge clk);
    rr_if.rq1_valid = 1'b0;
    #1;
    check_eq("bp_alu_op", rr_if.alu_op, 3'b110);
    @(negedge clk); #1;
    check_eq("bp_rs_valid", rr_if.rs_valid, 1);
    check_eq("bp_rs_data", rr_if.rs_data, 8'h00);
    check_eq("bp_rs_id", rr_if.rs_id, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rr_if.rq0_valid = 1'b1;
      rr_if.rq1_valid = 1'b1;
      #1;
      check_eq("bp_hold_rs_valid", rr_if.rs_valid, 1);
      check_eq("bp_hold_rs_data", rr_if.rs_data, 8'h00);
      check_eq("bp_hold_rs_id", rr_if.rs_id, 1);
      check_eq("bp_hold_rq0_ready", rr_if.rq0_ready, 0);
      check_eq("bp_hold_rq1_ready", rr_if.rq1_ready, 0);
    end
    @(negedge clk);
    rr_if.rs_ready = 1'b1;
    #1;
    check_eq("bp_release_rs_valid", rr_if.rs_valid, 1);
    check_eq("bp_release_rq0_ready", rr_if.rq0_ready, 0);
    @(negedge clk); #1;
    check_eq("bp_idle_rs_valid", rr_if.rs_valid, 0);
    check_eq("bp_idle_rq0_ready", rr_if.rq0_ready, 1);
    check_eq("bp_idle_rq1_ready", rr_if.rq1_ready, 0);
    rr_if.rq0_valid = 1'b0;
    rr_if.rq1_valid = 1'b0;

    // Reset mid-EXEC after granting rq0: in-flight op dropped, next tie still goes to rq0
    apply_reset();
    @(negedge clk);
    rr_if.rs_ready = 1'b1;
    rr_if.rq0_valid = 1'b1; rr_if.rq0_a = 8'h33; rr_if.rq0_b = 8'h44; rr_if.rq0_op = 3'b000;
    #1;
    check_eq("mid_rq0_ready", rr_if.rq0_ready, 1);
    @(negedge clk);
    rr_if.rq0_valid = 1'b0;
    #1;
    check_eq("mid_exec_alu_a", rr_if.alu_a, 8'h33);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rs_valid", rr_if.rs_valid, 0);
    check_eq("mid_rst_alu_a", rr_if.alu_a, 0);
    check_eq("mid_rst_alu_b", rr_if.alu_b, 0);
    check_eq("mid_rst_alu_op", rr_if.alu_op, 0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check_eq("mid_no_resp", rr_if.rs_valid, 0);
    end
    @(negedge clk);
    rr_if.rq0_valid = 1'b1;
    rr_if.rq1_valid = 1'b1;
    #1;
    check_eq("mid_tie_rq0_ready", rr_if.rq0_ready, 1);
    check_eq("mid_tie_rq1_ready", rr_if.rq1_ready, 0);
    rr_if.rq0_valid = 1'b0;
    rr_if.rq1_valid = 1'b0;

`ifdef ULA_ARB_STATS_EN
    apply_reset();
    #1;
    check_eq("stats_rst_gnt0", gnt0_cnt, 0);
    check_eq("stats_rst_gnt1", gnt1_cnt, 0);
    do_op(1'b0, 8'h01, 8'h02, 3'b000);
    do_op(1'b1, 8'h0C, 8'h0A, 3'b001);
    do_op(1'b0, 8'h0C, 8'h0A, 3'b010);
    do_op(1'b1, 8'h10, 8'h01, 3'b101);
    do_op(1'b0, 8'h00, 8'h7F, 3'b111);
    #1;
    check_eq("stats_gnt0", gnt0_cnt, 3);
    check_eq("stats_gnt1", gnt1_cnt, 2);
    @(negedge clk);
    rr_if.rs_ready = 1'b1;
    rr_if.rq0_valid = 1'b1;
    stats_clr = 1'b1;
    #1;
    check_eq("stats_clr_rq0_ready", rr_if.rq0_ready, 1);
    @(negedge clk);
    rr_if.rq0_valid = 1'b0;
    stats_clr = 1'b0;
    #1;
    check_eq("stats_clr_gnt0", gnt0_cnt, 0);
    check_eq("stats_clr_gnt1", gnt1_cnt, 0);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
